hack_data_memory: RTL and testbench
===================================

Name: hack_data_memory

Overview:
Memory-side responder for the Hack CPU data bus: accepts addressM/outM/writeM from the CPU and returns inM.
- Maps 16K words of data RAM, an 8K-word screen buffer and a keyboard register at the standard Hack addresses.
- The keyboard register is fed through a small valid/ready FIFO.
- The screen buffer has an independent registered read port for display scan-out.
- Sits between the CPU and the display and keyboard front-ends.

Parameters:
RAM_WORDS, 16384, data RAM depth (words); addresses at or above RAM_WORDS inside 0x0000-0x3FFF read 0 and ignore writes
SCR_WORDS, 8192, screen buffer depth (words)
KBD_DEPTH, 4, keyboard FIFO entries (power of 2, minimum 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
addressM  input  16  CPU data address
outM  input  16  CPU write data
writeM  input  1  CPU write enable
inM  output  16  read data to CPU (combinational from addressM)
key_code  input  16  keyboard scan code
key_valid  input  1  key_code valid
key_ready  output  1  FIFO can accept (= not full)
scr_addr  input  13  display scan read address
scr_data  output  16  display scan read data, 1-cycle latency

Behaviour:
- Address map:
  - 0x0000-0x3FFF: RAM.
  - 0x4000-0x5FFF: screen (index = addressM-0x4000).
  - 0x6000: keyboard.
  - 0x6001-0xFFFF: unmapped; reads return 0, writes are ignored.
- inM is combinational from addressM and current storage; same-cycle read, as the CPU requires.
- RAM and screen writes:
  - Commit on the rising edge when writeM=1.
  - inM reflects the new value from the following cycle.
- Keyboard read (0x6000):
  - Returns the FIFO head, or 0x0000 when the FIFO is empty.
  - Non-destructive.
- Keyboard pop:
  - Any write (writeM=1) to 0x6000 pops the head; the data value is ignored.
  - A pop while empty is ignored.
- Keyboard push:
  - Occurs when key_valid && key_ready on the rising edge.
  - key_ready = (count != KBD_DEPTH); it depends on count only, never on a same-cycle pop.
- Simultaneous push and pop with 0 < count < KBD_DEPTH: count is unchanged, head advances, new entry is appended at the tail.
- Simultaneous push and pop with count=0: the push is taken, the pop is ignored, count becomes 1.
- FIFO pointers wrap modulo KBD_DEPTH; count ranges 0..KBD_DEPTH.
- Scan port:
  - scr_data is registered from screen[scr_addr] each cycle.
  - A same-cycle CPU write to the same screen word returns the old data (read-before-write); the new data appears on the next read.
- Reset (synchronous, takes priority over all other activity):
  - FIFO pointers and count go to 0, so key_ready=1 and a keyboard read returns 0.
  - scr_data goes to 0x0000.
  - RAM and screen contents are not cleared.
  - A push or pop in the reset cycle is discarded.
- No stalls: every CPU access completes in its cycle.

Optional Feature:
HACK_MEM_BOUNDS_CHECK_EN
- Defined:
  - Adds output addr_err (1 bit), reset value 0.
  - addr_err is sticky, set on the edge of any write to an unmapped address (0x6001-0xFFFF, or RAM index >= RAM_WORDS).
  - Cleared only by reset.
- Undefined: port and logic are absent; unmapped writes are silently ignored.

Test Plan:
- Write 0x1234 to 0x0010, then drive addressM=0x0010 with writeM=0 -> inM=0x1234 in the next cycle; a read of 0x0011 is unaffected.
- Write 0xBEEF to 0x4005, then scr_addr=5 -> scr_data=0xBEEF one cycle later. A same-cycle write of 0x0001 to 0x4005 with scr_addr=5 -> scr_data shows the old value, then 0x0001 on the following read.
- Push key codes 0x0041, 0x0042, 0x0043, 0x0044 with KBD_DEPTH=4 -> key_ready=0. Read 0x6000 -> 0x0041; a 5th key_valid is not accepted.
- Write to 0x6000 (pop) while pushing 0x0045 at count=2 -> count stays 2, read 0x6000 returns the second entry. Pop until empty -> read 0x6000 returns 0x0000 and a further pop leaves count=0.
- Assert reset with FIFO count=3 and RAM[0x0010]=0x1234 -> key_ready=1, read 0x6000=0x0000, scr_data=0, RAM[0x0010] still 0x1234.
- With HACK_MEM_BOUNDS_CHECK_EN, write to 0x7000 -> addr_err=1 on the next cycle and it stays set through subsequent valid accesses until reset; a read of 0x7000 returns 0x0000.

Source files
------------

// File: rtl/hack_data_memory.sv
// rtl/hack_data_memory.sv - Hack CPU data bus responder: RAM, screen buffer, keyboard FIFO.
// Optional sticky unmapped-write flag addr_err under HACK_MEM_BOUNDS_CHECK_EN.
module hack_data_memory #(
  parameter int RAM_WORDS = 16384,
  parameter int SCR_WORDS = 8192,
  parameter int KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data
`ifdef HACK_MEM_BOUNDS_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int RA = $clog2(RAM_WORDS);
  localparam int SA = $clog2(SCR_WORDS);
  localparam int PW = $clog2(KBD_DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(KBD_DEPTH);

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCR_WORDS];
  logic [15:0] r_kbd [KBD_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [15:0]   r_scr_data;

  logic w_ram_sel;
  logic w_ram_ok;
  logic w_scr_sel;
  logic w_scr_ok;
  logic w_kbd_sel;
  logic w_push;
  logic w_pop;
  logic w_ram_idx_ok;
  logic w_scr_idx_ok;

  // RAM window is the whole low 16K; depth below that leaves a hole that reads 0.
  assign w_ram_sel    = (addressM[15:14] == 2'b00);
  assign w_ram_idx_ok = ({16'd0, addressM} < RAM_WORDS);
  assign w_ram_ok     = w_ram_sel && w_ram_idx_ok;
  assign w_scr_sel    = (addressM[15:13] == 3'b010);
  assign w_scr_idx_ok = ({19'd0, addressM[12:0]} < SCR_WORDS);
  assign w_scr_ok     = w_scr_sel && w_scr_idx_ok;
  assign w_kbd_sel    = (addressM == 16'h6000);

  assign key_ready = (r_count != C_DEPTH);
  assign w_push    = key_valid && key_ready;
  assign w_pop     = writeM && w_kbd_sel && (r_count != '0);

  always_comb begin
    inM = 16'h0000;
    if (w_ram_ok) begin
      inM = r_ram[addressM[RA-1:0]];
    end else if (w_scr_ok) begin
      inM = r_scr[addressM[SA-1:0]];
    end else if (w_kbd_sel && (r_count != '0)) begin
      inM = r_kbd[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && writeM && w_ram_ok) begin
      r_ram[addressM[RA-1:0]] <= outM;
    end
  end

  // Scan read samples before the CPU write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!reset && writeM && w_scr_ok) begin
      r_scr[addressM[SA-1:0]] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scr_data <= 16'h0000;
    end else begin
      r_scr_data <= r_scr[scr_addr[SA-1:0]];
    end
  end

  assign scr_data = r_scr_data;

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_kbd[r_tail] <= key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef HACK_MEM_BOUNDS_CHECK_EN
  logic w_unmapped_wr;
  logic r_addr_err;

  assign w_unmapped_wr = writeM && ((addressM > 16'h6000) || (w_ram_sel && !w_ram_idx_ok));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_unmapped_wr) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// tb/tb_hack_data_memory.sv - directed self-checking bench for hack_data_memory.
module tb_hack_data_memory;

  logic        clk;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] key_code;
  logic        key_valid;
  logic        key_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
`ifdef HACK_MEM_BOUNDS_CHECK_EN
  logic        addr_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hack_data_memory dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data)
`ifdef HACK_MEM_BOUNDS_CHECK_EN
    ,
    .addr_err  (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addressM = a;
    #1;
    check(tag, inM, exp);
  endtask

  task automatic push_key(input logic [15:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addressM = 16'h0000; outM = 16'h0000; writeM = 1'b0;
    key_code = 16'h0000; key_valid = 1'b0; scr_addr = 13'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_key_ready", {15'd0, key_ready}, 16'h0001);
    check("rst_scr_data", scr_data, 16'h0000);
    read_chk("rst_kbd_read", 16'h6000, 16'h0000);
`ifdef HACK_MEM_BOUNDS_CHECK_EN
    check("rst_addr_err", {15'd0, addr_err}, 16'h0000);
`endif

    cpu_write(16'h0011, 16'h5555);
    cpu_write(16'h0010, 16'h1234);
    read_chk("ram_0010", 16'h0010, 16'h1234);
    read_chk("ram_0011", 16'h0011, 16'h5555);
    cpu_write(16'h3FFF, 16'hA5A5);
    read_chk("ram_3fff", 16'h3FFF, 16'hA5A5);

    cpu_write(16'h4005, 16'hBEEF);
    read_chk("scr_cpu_read", 16'h4005, 16'hBEEF);
    scr_addr = 13'd5;
    tick();
    check("scan_beef", scr_data, 16'hBEEF);
    scr_addr = 13'd5;
    cpu_write(16'h4005, 16'h0001);
    check("scan_rbw_old", scr_data, 16'hBEEF);
    tick();
    check("scan_rbw_new", scr_data, 16'h0001);

    cpu_write(16'h7000, 16'hAAAA);
    read_chk("unmapped_read", 16'h7000, 16'h0000);
`ifdef HACK_MEM_BOUNDS_CHECK_EN
    check("addr_err_set", {15'd0, addr_err}, 16'h0001);
    cpu_write(16'h0020, 16'h0007);
    tick();
    check("addr_err_sticky", {15'd0, addr_err}, 16'h0001);
`endif

    push_key(16'h0041);
    push_key(16'h0042);
    push_key(16'h0043);
    push_key(16'h0044);
    check("kbd_full_ready", {15'd0, key_ready}, 16'h0000);
    read_chk("kbd_head_41", 16'h6000, 16'h0041);
    push_key(16'h0099);
    read_chk("kbd_head_still_41", 16'h6000, 16'h0041);
    check("kbd_still_full", {15'd0, key_ready}, 16'h0000);

    cpu_write(16'h6000, 16'hFFFF);
    read_chk("kbd_head_42", 16'h6000, 16'h0042);
    cpu_write(16'h6000, 16'h0000);
    read_chk("kbd_head_43", 16'h6000, 16'h0043);
    check("kbd_ready_cnt2", {15'd0, key_ready}, 16'h0001);

    key_code = 16'h0045; key_valid = 1'b1;
    cpu_write(16'h6000, 16'h0000);
    key_valid = 1'b0;
    read_chk("kbd_pushpop_head", 16'h6000, 16'h0044);
    check("kbd_pushpop_ready", {15'd0, key_ready}, 16'h0001);
    cpu_write(16'h6000, 16'h0000);
    read_chk("kbd_head_45", 16'h6000, 16'h0045);
    cpu_write(16'h6000, 16'h0000);
    read_chk("kbd_empty", 16'h6000, 16'h0000);
    cpu_write(16'h6000, 16'h0000);
    read_chk("kbd_empty_pop", 16'h6000, 16'h0000);

    key_code = 16'h0046; key_valid = 1'b1;
    cpu_write(16'h6000, 16'h0000);
    key_valid = 1'b0;
    read_chk("kbd_empty_pushpop", 16'h6000, 16'h0046);
    cpu_write(16'h6000, 16'h0000);
    read_chk("kbd_one_pop", 16'h6000, 16'h0000);

    push_key(16'h0051);
    push_key(16'h0052);
    push_key(16'h0053);
    read_chk("kbd_cnt3_head", 16'h6000, 16'h0051);
    check("pre_rst_scan", scr_data, 16'h0001);
    reset = 1'b1; key_code = 16'h0054; key_valid = 1'b1;
    addressM = 16'h6000; writeM = 1'b1;
    tick();
    reset = 1'b0; key_valid = 1'b0; writeM = 1'b0;
    #1;
    check("rst2_key_ready", {15'd0, key_ready}, 16'h0001);
    check("rst2_scr_data", scr_data, 16'h0000);
    read_chk("rst2_kbd_read", 16'h6000, 16'h0000);
    read_chk("rst2_ram_kept", 16'h0010, 16'h1234);
`ifdef HACK_MEM_BOUNDS_CHECK_EN
    check("rst2_addr_err", {15'd0, addr_err}, 16'h0000);
`endif
    tick();
    check("rst2_scr_kept", scr_data, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
